// File: rtl/hazard_unit_p.sv
// Hazard and forwarding controller for a 5-stage pipeline.
// Keeps a shadow pipeline of register tags for the EX, MEM and WB slots.
// Drives stall, flush, EX forwarding selects and ID bypass selects, and counts stall/flush events.
module hazard_unit_p #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  mem_branch_taken,
  output logic                  stall,
  output logic                  flush_ifid,
  output logic                  flush_idex,
  output logic                  flush_exmem,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  id_byp_a,
  output logic                  id_byp_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // EX slot: producer tags plus the consumer tags used for forwarding.
  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_regwrite_q, ex_regwrite_d;
  logic                  ex_memread_q, ex_memread_d;
  logic [REG_ADDR_W-1:0] ex_rs_q, ex_rs_d;
  logic [REG_ADDR_W-1:0] ex_rt_q, ex_rt_d;
  logic                  ex_uses_rs_q, ex_uses_rs_d;
  logic                  ex_uses_rt_q, ex_uses_rt_d;

  // MEM and WB slots; memread only matters while the load sits in EX.
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_regwrite_q, mem_regwrite_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic                  wb_regwrite_q, wb_regwrite_d;

  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;

  logic ex_hit, mem_hit, wb_hit, raw_stall, branch;

  // A producer slot writes a non-zero register that the consumer actually reads.
  function automatic logic match(input logic                  v,
                                 input logic                  rw,
                                 input logic [REG_ADDR_W-1:0] rd,
                                 input logic [REG_ADDR_W-1:0] r,
                                 input logic                  uses);
    return v & rw & uses & (rd == r) & (r != '0);
  endfunction

  // Hazard detection, flush and forwarding selects.
  always_comb begin
    stall       = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    flush_exmem = 1'b0;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    id_byp_a    = 1'b0;
    id_byp_b    = 1'b0;

    ex_hit  = match(ex_valid_q, ex_regwrite_q, ex_rd_q, id_rs, id_uses_rs) |
              match(ex_valid_q, ex_regwrite_q, ex_rd_q, id_rt, id_uses_rt);
    mem_hit = match(mem_valid_q, mem_regwrite_q, mem_rd_q, id_rs, id_uses_rs) |
              match(mem_valid_q, mem_regwrite_q, mem_rd_q, id_rt, id_uses_rt);
    wb_hit  = match(wb_valid_q, wb_regwrite_q, wb_rd_q, id_rs, id_uses_rs) |
              match(wb_valid_q, wb_regwrite_q, wb_rd_q, id_rt, id_uses_rt);

    if (FWD_EN != 0) begin
      raw_stall = id_valid & ex_hit & ex_memread_q;
    end else begin
      raw_stall = id_valid & (ex_hit | mem_hit | wb_hit);
    end

    // Branch flush wins over stall; reset wins over everything.
    branch      = mem_branch_taken & ~rst;
    stall       = raw_stall & ~branch & ~rst;
    flush_ifid  = branch;
    flush_idex  = branch;
    flush_exmem = branch;

    if ((FWD_EN != 0) && !rst) begin
      if (match(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rs_q, ex_valid_q & ex_uses_rs_q)) begin
        fwd_a = 2'b01;
      end else if (match(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_rs_q, ex_valid_q & ex_uses_rs_q)) begin
        fwd_a = 2'b10;
      end
      if (match(mem_valid_q, mem_regwrite_q, mem_rd_q, ex_rt_q, ex_valid_q & ex_uses_rt_q)) begin
        fwd_b = 2'b01;
      end else if (match(wb_valid_q, wb_regwrite_q, wb_rd_q, ex_rt_q, ex_valid_q & ex_uses_rt_q)) begin
        fwd_b = 2'b10;
      end
      id_byp_a = match(wb_valid_q, wb_regwrite_q, wb_rd_q, id_rs, id_uses_rs);
      id_byp_b = match(wb_valid_q, wb_regwrite_q, wb_rd_q, id_rt, id_uses_rt);
    end
  end

  // Shadow pipeline advance and saturating counters.
  always_comb begin
    wb_valid_d     = mem_valid_q;
    wb_rd_d        = mem_rd_q;
    wb_regwrite_d  = mem_regwrite_q;

    mem_valid_d    = ex_valid_q;
    mem_rd_d       = ex_rd_q;
    mem_regwrite_d = ex_regwrite_q;
    if (flush_exmem) begin
      mem_valid_d    = 1'b0;
      mem_rd_d       = '0;
      mem_regwrite_d = 1'b0;
    end

    ex_valid_d    = 1'b0;
    ex_rd_d       = '0;
    ex_regwrite_d = 1'b0;
    ex_memread_d  = 1'b0;
    ex_rs_d       = '0;
    ex_rt_d       = '0;
    ex_uses_rs_d  = 1'b0;
    ex_uses_rt_d  = 1'b0;
    if (id_valid && !stall && !flush_idex) begin
      ex_valid_d    = 1'b1;
      ex_rd_d       = id_rd;
      ex_regwrite_d = id_regwrite;
      ex_memread_d  = id_memread;
      ex_rs_d       = id_rs;
      ex_rt_d       = id_rt;
      ex_uses_rs_d  = id_uses_rs;
      ex_uses_rt_d  = id_uses_rt;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    flush_cnt_d = flush_cnt_q;
    if (mem_branch_taken && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= '0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_uses_rs_q   <= 1'b0;
      ex_uses_rt_q   <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_regwrite_q  <= ex_regwrite_d;
      ex_memread_q   <= ex_memread_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_uses_rs_q   <= ex_uses_rs_d;
      ex_uses_rt_q   <= ex_uses_rt_d;
      mem_valid_q    <= mem_valid_d;
      mem_rd_q       <= mem_rd_d;
      mem_regwrite_q <= mem_regwrite_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_regwrite_q  <= wb_regwrite_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  // Counters read as zero while reset is held.
  assign stall_count = rst ? '0 : stall_cnt_q;
  assign flush_count = rst ? '0 : flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit_p.sv
// Table-driven bench for hazard_unit_p: forwarding, interlock-only and narrow-counter instances.
module tb_hazard_unit_p;

  typedef struct packed {
    logic       rst; logic br; logic v;
    logic [4:0] rs; logic urs; logic [4:0] rt; logic urt;
    logic [4:0] rd; logic rw; logic mr;
  } in_t;

  typedef struct packed {
    logic stall; logic [2:0] fl; logic [1:0] fa; logic [1:0] fb;
    logic ba; logic bb; logic [15:0] sc; logic [15:0] fc;
  } out_t;

  typedef struct packed { logic [1:0] dut; in_t i; out_t o; } vec_t;
  typedef struct packed { logic [1:0] dut; logic [15:0] idx; out_t o; } exp_t;

  logic clk = 1'b0;
  in_t  drv;

  logic s0, fi0, fe0, fx0, ba0, bb0; logic [1:0] fa0, fb0; logic [15:0] sc0, fc0;
  logic s1, fi1, fe1, fx1, ba1, bb1; logic [1:0] fa1, fb1; logic [15:0] sc1, fc1;
  logic s2, fi2, fe2, fx2, ba2, bb2; logic [1:0] fa2, fb2; logic [1:0]  sc2, fc2;
  out_t outs [3];

  vec_t vecs [$];
  exp_t sb [$];
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  hazard_unit_p u_fwd (
    .clk(clk), .rst(drv.rst), .id_valid(drv.v), .id_rs(drv.rs), .id_rt(drv.rt),
    .id_uses_rs(drv.urs), .id_uses_rt(drv.urt), .id_rd(drv.rd), .id_regwrite(drv.rw),
    .id_memread(drv.mr), .mem_branch_taken(drv.br), .stall(s0), .flush_ifid(fi0),
    .flush_idex(fe0), .flush_exmem(fx0), .fwd_a(fa0), .fwd_b(fb0), .id_byp_a(ba0),
    .id_byp_b(bb0), .stall_count(sc0), .flush_count(fc0)
  );

  hazard_unit_p #(.FWD_EN(0)) u_ilk (
    .clk(clk), .rst(drv.rst), .id_valid(drv.v), .id_rs(drv.rs), .id_rt(drv.rt),
    .id_uses_rs(drv.urs), .id_uses_rt(drv.urt), .id_rd(drv.rd), .id_regwrite(drv.rw),
    .id_memread(drv.mr), .mem_branch_taken(drv.br), .stall(s1), .flush_ifid(fi1),
    .flush_idex(fe1), .flush_exmem(fx1), .fwd_a(fa1), .fwd_b(fb1), .id_byp_a(ba1),
    .id_byp_b(bb1), .stall_count(sc1), .flush_count(fc1)
  );

  hazard_unit_p #(.FWD_EN(0), .CNT_W(2)) u_sat (
    .clk(clk), .rst(drv.rst), .id_valid(drv.v), .id_rs(drv.rs), .id_rt(drv.rt),
    .id_uses_rs(drv.urs), .id_uses_rt(drv.urt), .id_rd(drv.rd), .id_regwrite(drv.rw),
    .id_memread(drv.mr), .mem_branch_taken(drv.br), .stall(s2), .flush_ifid(fi2),
    .flush_idex(fe2), .flush_exmem(fx2), .fwd_a(fa2), .fwd_b(fb2), .id_byp_a(ba2),
    .id_byp_b(bb2), .stall_count(sc2), .flush_count(fc2)
  );

  assign outs[0] = {s0, fi0, fe0, fx0, fa0, fb0, ba0, bb0, sc0, fc0};
  assign outs[1] = {s1, fi1, fe1, fx1, fa1, fb1, ba1, bb1, sc1, fc1};
  assign outs[2] = {s2, fi2, fe2, fx2, fa2, fb2, ba2, bb2, {14'd0, sc2}, {14'd0, fc2}};

  function automatic in_t mk(input int r, input int b, input int v, input int rs, input int urs,
                             input int rt, input int urt, input int rd, input int rw, input int mr);
    in_t m;
    m.rst = 1'(r); m.br = 1'(b); m.v = 1'(v);
    m.rs = 5'(rs); m.urs = 1'(urs); m.rt = 5'(rt); m.urt = 1'(urt);
    m.rd = 5'(rd); m.rw = 1'(rw); m.mr = 1'(mr);
    return m;
  endfunction

  function automatic in_t f_nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic in_t f_rst();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic in_t f_lw(input int rd, input int rs);
    return mk(0, 0, 1, rs, 1, 0, 0, rd, 1, 1);
  endfunction
  function automatic in_t f_alu(input int rd, input int rs, input int rt);
    return mk(0, 0, 1, rs, 1, rt, 1, rd, 1, 0);
  endfunction
  function automatic in_t with_br(input in_t x);
    in_t y;
    y = x; y.br = 1'b1;
    return y;
  endfunction
  function automatic in_t with_rst(input in_t x);
    in_t y;
    y = x; y.rst = 1'b1;
    return y;
  endfunction

  // Expected outputs: fl = 1 means all three flushes asserted.
  function automatic out_t e(input int st, input int fl, input int fa, input int fb,
                             input int ba, input int bb, input int sc, input int fc);
    out_t o;
    o.stall = 1'(st);
    o.fl    = (fl != 0) ? 3'b111 : 3'b000;
    o.fa    = 2'(fa); o.fb = 2'(fb);
    o.ba    = 1'(ba); o.bb = 1'(bb);
    o.sc    = 16'(sc); o.fc = 16'(fc);
    return o;
  endfunction

  task automatic add(input int d, input in_t i, input out_t o);
    vec_t v;
    v.dut = 2'(d); v.i = i; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] expv);
    n_tot++;
    if (act == expv) n_pass++;
    else $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, expv);
  endtask

  // Scoreboard check half a cycle after each vector is applied.
  always @(negedge clk) begin
    exp_t x;
    out_t a;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      a = outs[x.dut];
      chk("stall",    int'(x.idx), 32'(a.stall), 32'(x.o.stall));
      chk("flush",    int'(x.idx), 32'(a.fl), 32'(x.o.fl));
      chk("fwd_byp",  int'(x.idx), 32'({a.fa, a.fb, a.ba, a.bb}), 32'({x.o.fa, x.o.fb, x.o.ba, x.o.bb}));
      chk("counters", int'(x.idx), {a.sc, a.fc}, {x.o.sc, x.o.fc});
    end
  end

  initial begin
    exp_t x;
    drv = f_rst();

    // Forwarding: load-use stall, then forward from WB.
    add(0, f_rst(),          e(0,0,0,0,0,0,0,0));
    add(0, f_nop(),          e(0,0,0,0,0,0,0,0));
    add(0, f_lw(2,1),        e(0,0,0,0,0,0,0,0));
    add(0, f_alu(3,2,4),     e(1,0,0,0,0,0,0,0));
    add(0, f_alu(3,2,4),     e(0,0,0,0,0,0,1,0));
    add(0, f_nop(),          e(0,0,2,0,0,0,1,0));
    // Two r5 producers then sub r6,r5,r5: MEM wins; then ID bypass and WB forward.
    add(0, f_alu(5,1,1),     e(0,0,0,0,0,0,1,0));
    add(0, f_alu(5,1,1),     e(0,0,0,0,0,0,1,0));
    add(0, f_alu(6,5,5),     e(0,0,0,0,0,0,1,0));
    add(0, f_nop(),          e(0,0,1,1,0,0,1,0));
    add(0, f_alu(7,5,6),     e(0,0,0,0,1,0,1,0));
    add(0, f_nop(),          e(0,0,0,2,0,0,1,0));
    // Branch with load-use pending: flush beats stall, EX and MEM cleared.
    add(0, f_rst(),          e(0,0,0,0,0,0,0,0));
    add(0, f_lw(2,1),        e(0,0,0,0,0,0,0,0));
    add(0, with_br(f_alu(3,2,4)), e(0,1,0,0,0,0,0,0));
    add(0, f_alu(3,2,4),     e(0,0,0,0,0,0,0,1));
    add(0, f_nop(),          e(0,0,0,0,0,0,0,1));
    // r0 producer and a regwrite=0 load never create hazards.
    add(0, f_rst(),          e(0,0,0,0,0,0,0,0));
    add(0, f_lw(0,1),        e(0,0,0,0,0,0,0,0));
    add(0, f_alu(3,0,0),     e(0,0,0,0,0,0,0,0));
    add(0, f_nop(),          e(0,0,0,0,0,0,0,0));
    add(0, mk(0,0,1,1,1,0,0,8,0,1), e(0,0,0,0,0,0,0,0));
    add(0, f_alu(9,8,8),     e(0,0,0,0,0,0,0,0));
    add(0, f_nop(),          e(0,0,0,0,0,0,0,0));
    // Interlock-only: three stall cycles, no forwarding; then reset mid-stall.
    add(1, f_rst(),          e(0,0,0,0,0,0,0,0));
    add(1, f_alu(5,1,1),     e(0,0,0,0,0,0,0,0));
    add(1, f_alu(6,5,1),     e(1,0,0,0,0,0,0,0));
    add(1, f_alu(6,5,1),     e(1,0,0,0,0,0,1,0));
    add(1, f_alu(6,5,1),     e(1,0,0,0,0,0,2,0));
    add(1, f_alu(6,5,1),     e(0,0,0,0,0,0,3,0));
    add(1, f_nop(),          e(0,0,0,0,0,0,3,0));
    add(1, f_alu(5,1,1),     e(0,0,0,0,0,0,3,0));
    add(1, f_alu(6,5,1),     e(1,0,0,0,0,0,3,0));
    add(1, with_rst(f_alu(6,5,1)), e(0,0,0,0,0,0,0,0));
    add(1, f_alu(6,5,1),     e(0,0,0,0,0,0,0,0));
    // Two-bit counters: five stall events saturate at 3, four flushes saturate at 3.
    add(2, f_rst(),          e(0,0,0,0,0,0,0,0));
    add(2, f_alu(5,1,1),     e(0,0,0,0,0,0,0,0));
    add(2, f_alu(6,5,1),     e(1,0,0,0,0,0,0,0));
    add(2, f_alu(6,5,1),     e(1,0,0,0,0,0,1,0));
    add(2, f_alu(6,5,1),     e(1,0,0,0,0,0,2,0));
    add(2, f_alu(6,5,1),     e(0,0,0,0,0,0,3,0));
    add(2, f_alu(7,1,1),     e(0,0,0,0,0,0,3,0));
    add(2, f_nop(),          e(0,0,0,0,0,0,3,0));
    add(2, f_alu(8,7,7),     e(1,0,0,0,0,0,3,0));
    add(2, f_alu(8,7,7),     e(1,0,0,0,0,0,3,0));
    add(2, f_alu(8,7,7),     e(0,0,0,0,0,0,3,0));
    add(2, with_rst(with_br(f_nop())), e(0,0,0,0,0,0,0,0));
    add(2, f_nop(),          e(0,0,0,0,0,0,0,0));
    add(2, with_br(f_nop()), e(0,1,0,0,0,0,0,0));
    add(2, with_br(f_nop()), e(0,1,0,0,0,0,0,1));
    add(2, with_br(f_nop()), e(0,1,0,0,0,0,0,2));
    add(2, with_br(f_nop()), e(0,1,0,0,0,0,0,3));
    add(2, f_nop(),          e(0,0,0,0,0,0,0,3));

    for (int i = 0; i < int'(vecs.size()); i++) begin
      @(posedge clk);
      #1;
      drv   = vecs[i].i;
      x.dut = vecs[i].dut;
      x.idx = 16'(i);
      x.o   = vecs[i].o;
      sb.push_back(x);
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_tot++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/hazard_unit_p.md
Name: hazard_unit_p

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined datapath (IF, ID, EX, MEM, WB); it is the successor to the current stall-free pipeline.
- Keeps its own shadow pipeline of destination/source tags for the EX, MEM and WB slots.
- Drives stall, flush and forwarding-select signals to the pipeline buffers and the ALU operand muxes.
- Mode parameter selects full forwarding or stall-only interlocking; also provides stall and flush performance counters.

Parameters:
REG_ADDR_W, 5, register-address width; register 0 is hard-wired zero and never creates a hazard.
FWD_EN, 1, 1 = forwarding with load-use stall; 0 = interlock-only: stall until the producer has left WB.
CNT_W, 16, width of the saturating performance counters.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
id_valid  in  1  ID stage holds a real instruction.
id_rs, id_rt  in  REG_ADDR_W  source registers of the ID instruction.
id_uses_rs, id_uses_rt  in  1  the ID instruction actually reads rs / rt.
id_rd  in  REG_ADDR_W  destination after the RegDst mux.
id_regwrite, id_memread  in  1  control bits of the ID instruction.
mem_branch_taken  in  1  Branch AND zero, resolved in MEM.
stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
flush_ifid, flush_idex, flush_exmem  out  1  zero the control fields of those buffers at the next edge.
fwd_a, fwd_b  out  2  EX operand selects: 00 = ID/EX value, 01 = EX/MEM ALU result, 10 = MEM/WB write data.
id_byp_a, id_byp_b  out  1  ID-stage bypass: take WB write data instead of the register-bank read.
stall_count, flush_count  out  CNT_W  saturating event counters.

Behaviour:
- Shadow slots EX, MEM, WB: each holds {valid, rd, regwrite, memread}; the EX slot also holds rs, rt, uses_rs, uses_rt.
- Every edge: WB <= MEM, MEM <= EX (MEM is cleared instead if flush_exmem = 1).
- EX <= ID fields when id_valid & !stall & !flush_idex; otherwise EX is a bubble (valid = 0).
- Match(slot, r) = slot.valid & slot.regwrite & slot.rd == r & r != 0, qualified by the uses_ bit of the consumer.
- FWD_EN = 1:
  - stall = id_valid & (Match(EX, id_rs) | Match(EX, id_rt)) & EX.memread. This is the load-use case: exactly 1 stall cycle.
  - fwd_a = 01 if Match(MEM, EX.rs); else 10 if Match(WB, EX.rs); else 00. MEM has priority over WB. fwd_b uses EX.rt the same way.
  - id_byp_a/b = Match(WB, id_rs / id_rt).
- FWD_EN = 0:
  - stall = id_valid & any Match(EX | MEM | WB, id_rs / id_rt). Maximum 3 consecutive stall cycles.
  - fwd_a/b and id_byp_a/b are held at 0.
- Branch: when mem_branch_taken = 1, flush_ifid = flush_idex = flush_exmem = 1 in the same cycle (combinational). stall is forced to 0 that cycle; flush overrides stall.
- All outputs are combinational from the slot state and inputs, except the counters.
- Counters:
  - stall_count += 1 on each cycle with stall = 1.
  - flush_count += 1 on each cycle with mem_branch_taken = 1.
  - Both saturate at 2^CNT_W - 1 with no wrap.
- rst = 1: at the next edge all slots are invalid and both counters are 0.
  - While rst is high, all outputs are forced to 0; reset takes precedence over any branch or stall in progress.
  - After release, with no valid slots, outputs stay 0 until a hazard arises.
- A producer with rd = 0, or with regwrite = 0, never causes a stall, forward or bypass.

Test Plan:
- FWD_EN = 1, lw r2 then add r3, r2, r4 back-to-back -> stall = 1 for exactly 1 cycle. Next cycle fwd_a = 10 for the add. stall_count = 1.
- FWD_EN = 1, add r5 then sub r6, r5, r5 -> no stall; fwd_a = fwd_b = 01 when sub is in EX. Two producers of r5 in MEM and WB -> 01 wins.
- FWD_EN = 0, add r5 then sub r6, r5, r1 -> stall high 3 consecutive cycles. fwd_a stays 00. stall_count = 3.
- mem_branch_taken pulse with a load-use stall pending -> all three flushes = 1, stall = 0. The EX slot is a bubble next cycle. flush_count = 1.
- Producer writing r0 (lw r0 then add using r0) -> no stall, fwd = 00, byp = 0.
- Assert rst mid-stall, and separately drive CNT_W = 2 with 5 stall events -> outputs 0 and counters 0 after the reset edge. stall_count saturates at 3.
